// File: rtl/clk_div_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : clk_div_sched
//  Brief    : Runtime-reconfigurable 50%-duty clock divider (any N >= 2) with
//             glitch-free ratio changes applied only at period boundaries.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_div_sched #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             period_start,
  output logic             busy,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PEND  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_DEFAULT_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] C_MIN_DIV     = CNT_W'(2);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_div_cur, r_div_nxt, r_cnt;
  logic [CNT_W-1:0] w_div_cur_nxt, w_div_nxt_nxt, w_cnt_nxt, w_last_cnt;
  logic             r_hi_p, r_hi_n, r_odd, r_period_start, r_cfg_err;
  logic             w_active, w_wrap, w_accept, w_legal, w_load;

  assign w_active   = (r_state != S_IDLE);
  assign w_last_cnt = r_div_cur - CNT_W'(1);
  assign w_wrap     = (r_cnt == w_last_cnt);
  assign cfg_ready  = (r_state != S_PEND);
  assign w_accept   = cfg_valid & cfg_ready;
  assign w_legal    = (cfg_div >= C_MIN_DIV);
  assign w_load     = w_accept & w_legal;

  always_comb begin
    w_state_nxt   = r_state;
    w_div_cur_nxt = r_div_cur;
    w_div_nxt_nxt = r_div_nxt;
    w_cnt_nxt     = (w_active && !w_wrap) ? (r_cnt + CNT_W'(1)) : '0;
    case (r_state)
      S_IDLE: begin
        if (w_load) begin
          w_div_cur_nxt = cfg_div;
          w_div_nxt_nxt = cfg_div;
        end else if (en) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_load && w_wrap) begin
          // Accepted exactly on the boundary: apply now rather than a full period later.
          w_div_cur_nxt = cfg_div;
          w_div_nxt_nxt = cfg_div;
          w_state_nxt   = en ? S_RUN : S_DRAIN;
        end else if (w_load) begin
          w_div_nxt_nxt = cfg_div;
          w_state_nxt   = S_PEND;
        end else if (!en) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_PEND: begin
        if (w_wrap) begin
          w_div_cur_nxt = r_div_nxt;
          w_state_nxt   = en ? S_RUN : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (w_load) begin
          w_div_nxt_nxt = cfg_div;
        end
        if (w_wrap) begin
          w_div_cur_nxt = w_load ? cfg_div : r_div_nxt;
          w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // hi_p and r_odd are taken from the same cycle so a ratio swap never mixes
  // the old high flag with the new parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_div_cur      <= C_DEFAULT_DIV;
      r_div_nxt      <= C_DEFAULT_DIV;
      r_cnt          <= '0;
      r_hi_p         <= 1'b0;
      r_odd          <= C_DEFAULT_DIV[0];
      r_period_start <= 1'b0;
      r_cfg_err      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_div_cur      <= w_div_cur_nxt;
      r_div_nxt      <= w_div_nxt_nxt;
      r_cnt          <= w_cnt_nxt;
      r_hi_p         <= w_active && (r_cnt < (r_div_cur >> 1));
      r_odd          <= r_div_cur[0];
      r_period_start <= w_active && (r_cnt == '0);
      r_cfg_err      <= w_accept && !w_legal;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi_n <= 1'b0;
    end else begin
      r_hi_n <= r_hi_p;
    end
  end

  assign clk_out      = r_hi_p | (r_hi_n & r_odd);
  assign period_start = r_period_start;
  assign busy         = w_active;
  assign cfg_err      = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_clk_div_sched
//  Brief    : Scoreboard bench for clk_div_sched; each sample is one clk cycle
//             (clk_out in both halves, period_start, busy, cfg_ready, cfg_err).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_sched;

  logic       clk = 1'b0;
  logic       rst_n, en, cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready, clk_out, period_start, busy, cfg_err;

  typedef struct packed {
    logic h1;
    logic h2;
    logic ps;
    logic bz;
    logic rdy;
    logic err;
  } smp_t;

  smp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  clk_div_sched #(.CNT_W(8), .DEFAULT_DIV(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_div      (cfg_div),
    .cfg_ready    (cfg_ready),
    .clk_out      (clk_out),
    .period_start (period_start),
    .busy         (busy),
    .cfg_err      (cfg_err)
  );

  function automatic void push_idle(int count, logic bz);
    smp_t e;
    for (int i = 0; i < count; i++) begin
      e     = '0;
      e.bz  = bz;
      e.rdy = 1'b1;
      sb.push_back(e);
    end
  endfunction

  // Ideal 50% waveform: cycle j of an N period is high in its first half for
  // j < ceil(N/2) and in its second half for j < floor(N/2).
  function automatic void push_span(int n, int j0, int count, bit drop_last, logic rdy, logic err);
    smp_t e;
    for (int i = 0; i < count; i++) begin
      int j;
      j     = (j0 + i) % n;
      e     = '0;
      e.h1  = (j < (n + 1) / 2);
      e.h2  = (j < n / 2);
      e.ps  = (j == 0);
      e.bz  = !(drop_last && (i == count - 1));
      e.rdy = rdy;
      e.err = (i == 0) ? err : 1'b0;
      sb.push_back(e);
    end
  endfunction

  task automatic sample(output smp_t s);
    @(posedge clk);
    #2;
    s     = '0;
    s.h1  = clk_out;
    s.ps  = period_start;
    s.bz  = busy;
    s.rdy = cfg_ready;
    s.err = cfg_err;
    @(negedge clk);
    #2;
    s.h2 = clk_out;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    vectors += 5;
    if (clk_out !== 1'b0)      begin miscompares++; $display("FAIL reset_clk_out: got %b expected 0", clk_out); end
    if (cfg_ready !== 1'b1)    begin miscompares++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
    if (busy !== 1'b0)         begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (period_start !== 1'b0) begin miscompares++; $display("FAIL reset_period_start: got %b expected 0", period_start); end
    if (cfg_err !== 1'b0)      begin miscompares++; $display("FAIL reset_cfg_err: got %b expected 0", cfg_err); end
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      smp_t s, e;
      sample(s); e = sb.pop_front(); vectors++;
      if (s !== e) begin miscompares++; $display("FAIL reset_idle[%0d]: got %b expected %b", i, s, e); end
    end
  endtask

  task automatic test_default_run();
    do_reset();
    en = 1'b1;
    push_idle(1, 1'b1);
    push_span(5, 0, 15, 0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      smp_t s, e;
      sample(s); e = sb.pop_front(); vectors++;
      if (s !== e) begin miscompares++; $display("FAIL run5[%0d]: got %b expected %b", i, s, e); end
    end
    en = 1'b0;
    push_span(5, 0, 5, 1, 1'b1, 1'b0);
    push_idle(2, 1'b0);
    for (int i = 0; i < 7; i++) begin
      smp_t s, e;
      sample(s); e = sb.pop_front(); vectors++;
      if (s !== e) begin miscompares++; $display("FAIL stop5[%0d]: got %b expected %b", i, s, e); end
    end
  endtask

  task automatic test_idle_cfg();
    do_reset();
    cfg_valid = 1'b1;
    cfg_div   = 8'd4;
    push_idle(2, 1'b0);
    for (int i = 0; i < 2; i++) begin
      smp_t s, e;
      sample(s); e = sb.pop_front(); vectors++;
      if (s !== e) begin miscompares++; $display("FAIL idle_cfg[%0d]: got %b expected %b", i, s, e); end
      if (i == 0) cfg_valid = 1'b0;
    end
    en = 1'b1;
    push_idle(1, 1'b1);
    push_span(4, 0, 12, 0, 1'b1, 1'b0);
    for (int i = 0; i < 13; i++) begin
      smp_t s, e;
      sample(s); e = sb.pop_front(); vectors++;
      if (s !== e) begin miscompares++; $display("FAIL run4[%0d]: got %b expected %b", i, s, e); end
    end
  endtask

  task automatic test_retune();
    do_reset();
    en = 1'b1;
    push_idle(1, 1'b1);
    push_span(5, 0, 7, 0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      smp_t s, e;
      sample(s); e = sb.pop_front(); vectors++;
      if (s !== e) begin miscompares++; $display("FAIL pre_retune[%0d]: got %b expected %b", i, s, e); end
    end
    cfg_valid = 1'b1;
    cfg_div   = 8'd3;
    push_span(5, 2, 2, 0, 1'b0, 1'b0);
    push_span(5, 4, 1, 0, 1'b1, 1'b0);
    push_span(3, 0, 9, 0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      smp_t s, e;
      sample(s); e = sb.pop_front(); vectors++;
      if (s !== e) begin miscompares++; $display("FAIL retune3[%0d]: got %b expected %b", i, s, e); end
      if (i == 0) cfg_valid = 1'b0;
    end
  endtask

  task automatic test_cfg_err();
    do_reset();
    en = 1'b1;
    push_idle(1, 1'b1);
    push_span(5, 0, 7, 0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      smp_t s, e;
      sample(s); e = sb.pop_front(); vectors++;
      if (s !== e) begin miscompares++; $display("FAIL pre_err[%0d]: got %b expected %b", i, s, e); end
    end
    cfg_valid = 1'b1;
    cfg_div   = 8'd1;
    push_span(5, 2, 1, 0, 1'b1, 1'b1);
    push_span(5, 3, 7, 0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      smp_t s, e;
      sample(s); e = sb.pop_front(); vectors++;
      if (s !== e) begin miscompares++; $display("FAIL cfg_err[%0d]: got %b expected %b", i, s, e); end
      if (i == 0) cfg_valid = 1'b0;
    end
  endtask

  task automatic test_stop();
    do_reset();
    cfg_valid = 1'b1;
    cfg_div   = 8'd6;
    push_idle(1, 1'b0);
    push_idle(1, 1'b1);
    push_span(6, 0, 7, 0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      smp_t s, e;
      sample(s); e = sb.pop_front(); vectors++;
      if (s !== e) begin miscompares++; $display("FAIL run6[%0d]: got %b expected %b", i, s, e); end
      if (i == 0) begin cfg_valid = 1'b0; en = 1'b1; end
    end
    en = 1'b0;
    push_span(6, 1, 5, 1, 1'b1, 1'b0);
    push_idle(2, 1'b0);
    for (int i = 0; i < 7; i++) begin
      smp_t s, e;
      sample(s); e = sb.pop_front(); vectors++;
      if (s !== e) begin miscompares++; $display("FAIL stop6[%0d]: got %b expected %b", i, s, e); end
    end
    en = 1'b1;
    push_idle(1, 1'b1);
    push_span(6, 0, 12, 0, 1'b1, 1'b0);
    for (int i = 0; i < 13; i++) begin
      smp_t s, e;
      sample(s); e = sb.pop_front(); vectors++;
      if (s !== e) begin miscompares++; $display("FAIL restart6[%0d]: got %b expected %b", i, s, e); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cfg_valid = 1'b1;
    cfg_div   = 8'd7;
    push_idle(1, 1'b0);
    push_idle(1, 1'b1);
    push_span(7, 0, 2, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      smp_t s, e;
      sample(s); e = sb.pop_front(); vectors++;
      if (s !== e) begin miscompares++; $display("FAIL run7[%0d]: got %b expected %b", i, s, e); end
      if (i == 0) begin cfg_valid = 1'b0; en = 1'b1; end
    end
    // Leave a ratio pending so reset must also clear the PEND state.
    cfg_valid = 1'b1;
    cfg_div   = 8'd4;
    push_span(7, 2, 1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 1; i++) begin
      smp_t s, e;
      sample(s); e = sb.pop_front(); vectors++;
      if (s !== e) begin miscompares++; $display("FAIL pend7[%0d]: got %b expected %b", i, s, e); end
      cfg_valid = 1'b0;
    end
    @(posedge clk);
    #3;
    vectors += 2;
    if (clk_out !== 1'b1)   begin miscompares++; $display("FAIL pre_rst_clk_out: got %b expected 1", clk_out); end
    if (cfg_ready !== 1'b0) begin miscompares++; $display("FAIL pre_rst_cfg_ready: got %b expected 0", cfg_ready); end
    rst_n = 1'b0;
    #1;
    vectors += 4;
    if (clk_out !== 1'b0)      begin miscompares++; $display("FAIL async_clk_out: got %b expected 0", clk_out); end
    if (cfg_ready !== 1'b1)    begin miscompares++; $display("FAIL async_cfg_ready: got %b expected 1", cfg_ready); end
    if (busy !== 1'b0)         begin miscompares++; $display("FAIL async_busy: got %b expected 0", busy); end
    if (period_start !== 1'b0) begin miscompares++; $display("FAIL async_period_start: got %b expected 0", period_start); end
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(1, 1'b1);
    push_span(5, 0, 10, 0, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) begin
      smp_t s, e;
      sample(s); e = sb.pop_front(); vectors++;
      if (s !== e) begin miscompares++; $display("FAIL post_rst5[%0d]: got %b expected %b", i, s, e); end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    test_reset();
    test_default_run();
    test_idle_cfg();
    test_retune();
    test_cfg_err();
    test_stop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
